// File: rtl/dm_sba_engine.sv
// System-bus access engine: turns debug-module sbaddress/sbdata accesses into
// single bus transactions with size/alignment pre-check, byte-lane steering,
// autoincrement and a grant/response timeout.
//
// state    | meaning
// IDLE     | waiting for a read or write trigger
// REQ      | master_req_o raised, waiting for master_gnt_i
// WAIT_RSP | granted, waiting for master_r_valid_i
module dm_sba_engine #(
    parameter int unsigned BusWidth       = 32,
    parameter int unsigned TimeoutCycles  = 1024,
    parameter logic [3:0]  SupportedSizes = 4'b0111
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    output logic                  master_req_o,
    output logic [BusWidth-1:0]   master_add_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    input  logic                  sbaddress_write_valid_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic                  sbreadondata_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_read_valid_i,
    input  logic                  sbdata_write_valid_i,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic                  sberror_valid_o,
    output logic [2:0]            sberror_o
);
    localparam int unsigned BeW  = BusWidth / 8;
    localparam int unsigned OffW = $clog2(BeW);
    localparam int unsigned CntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = (TimeoutCycles == 0) ? '0 : CntW'(TimeoutCycles - 1);
    // 64-bit accesses can never be legal on a 32-bit bus
    localparam logic [3:0] SizeMask = (BusWidth == 32) ? (SupportedSizes & 4'b0111) : SupportedSizes;

    if (BusWidth != 32 && BusWidth != 64) begin : g_bad_width
        $fatal(1, "dm_sba_engine: BusWidth must be 32 or 64");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    state_e              state_q;
    logic [BusWidth-1:0] addr_q;
    logic [CntW-1:0]     cnt_q;
    logic                discard_q;
    logic                we_q;
    logic [1:0]          sz_q;
    logic [OffW-1:0]     off_q;

    logic [BusWidth-1:0] eff_addr;
    logic                trig_rd;
    logic                trig_wr;
    logic [1:0]          sz;
    logic                size_ok;
    logic                align_ok;
    logic                timeout;
    logic [7:0]          be_base;
    logic [BeW-1:0]      be_val;
    logic [BusWidth-1:0] wdata_val;
    logic [63:0]         m64;
    logic [BusWidth-1:0] rd_mask;
    logic [BusWidth-1:0] rd_val;

    // a trigger in the same cycle as an address write uses the new address
    assign eff_addr = sbaddress_write_valid_i ? sbaddress_i : addr_q;
    assign trig_rd  = (sbaddress_write_valid_i & sbreadonaddr_i) | (sbdata_read_valid_i & sbreadondata_i);
    assign trig_wr  = sbdata_write_valid_i;
    assign sz       = sbaccess_i[1:0];
    assign size_ok  = (sbaccess_i[2] == 1'b0) && SizeMask[sz];
    assign align_ok = (eff_addr[2:0] & ((3'd1 << sz) - 3'd1)) == 3'd0;
    assign timeout  = (TimeoutCycles != 0) && (cnt_q == CntLast);

    assign sbaddress_o = addr_q;
    assign sbbusy_o    = (state_q != IDLE);

    // byte enables and lane-replicated write data for the access being launched
    always_comb begin
        case (sz)
            2'd0:    be_base = 8'h01;
            2'd1:    be_base = 8'h03;
            2'd2:    be_base = 8'h0F;
            default: be_base = 8'hFF;
        endcase
        be_val = BeW'(16'(be_base) << eff_addr[OffW-1:0]);
        case (sz)
            2'd0:    wdata_val = {BeW{sbdata_i[7:0]}};
            2'd1:    wdata_val = {(BeW/2){sbdata_i[15:0]}};
            2'd2:    wdata_val = {(BeW/4){sbdata_i[31:0]}};
            default: wdata_val = sbdata_i;
        endcase
    end

    // read data brought down to lane 0 and zero-extended above the access size
    always_comb begin
        m64     = (sz_q == 2'd3) ? '1 : (64'd1 << (7'd8 << sz_q)) - 64'd1;
        rd_mask = m64[BusWidth-1:0];
        rd_val  = (master_r_rdata_i >> {off_q, 3'b000}) & rd_mask;
    end

    // engine FSM with registered bus and status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            cnt_q           <= '0;
            discard_q       <= 1'b0;
            we_q            <= 1'b0;
            sz_q            <= 2'd0;
            off_q           <= '0;
            master_req_o    <= 1'b0;
            master_add_o    <= '0;
            master_we_o     <= 1'b0;
            master_wdata_o  <= '0;
            master_be_o     <= '0;
            sbdata_o        <= '0;
            sbdata_valid_o  <= 1'b0;
            sberror_valid_o <= 1'b0;
            sberror_o       <= 3'd0;
        end else if (!dmactive_i) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            discard_q       <= 1'b0;
            master_req_o    <= 1'b0;
            master_add_o    <= '0;
            master_we_o     <= 1'b0;
            master_wdata_o  <= '0;
            master_be_o     <= '0;
            sbdata_valid_o  <= 1'b0;
            sberror_valid_o <= 1'b0;
            sberror_o       <= 3'd0;
        end else begin
            sbdata_valid_o  <= 1'b0;
            sberror_valid_o <= 1'b0;
            // the first response after a response timeout belongs to the dead access
            if (master_r_valid_i && discard_q) begin
                discard_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (sbaddress_write_valid_i) begin
                        addr_q <= sbaddress_i;
                    end
                    if (trig_wr || trig_rd) begin
                        if (!size_ok) begin
                            sberror_o       <= 3'd4;
                            sberror_valid_o <= 1'b1;
                        end else if (!align_ok) begin
                            sberror_o       <= 3'd3;
                            sberror_valid_o <= 1'b1;
                        end else begin
                            state_q        <= REQ;
                            cnt_q          <= '0;
                            master_req_o   <= 1'b1;
                            master_add_o   <= {eff_addr[BusWidth-1:OffW], {OffW{1'b0}}};
                            master_we_o    <= trig_wr;
                            master_wdata_o <= trig_wr ? wdata_val : '0;
                            master_be_o    <= be_val;
                            we_q           <= trig_wr;
                            sz_q           <= sz;
                            off_q          <= eff_addr[OffW-1:0];
                        end
                    end
                end
                REQ: begin
                    if (master_gnt_i) begin
                        state_q        <= WAIT_RSP;
                        cnt_q          <= '0;
                        master_req_o   <= 1'b0;
                        master_add_o   <= '0;
                        master_we_o    <= 1'b0;
                        master_wdata_o <= '0;
                        master_be_o    <= '0;
                    end else if (timeout) begin
                        // never granted, so no response can be outstanding
                        state_q         <= IDLE;
                        master_req_o    <= 1'b0;
                        master_add_o    <= '0;
                        master_we_o     <= 1'b0;
                        master_wdata_o  <= '0;
                        master_be_o     <= '0;
                        sberror_o       <= 3'd1;
                        sberror_valid_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                WAIT_RSP: begin
                    if (master_r_valid_i && !discard_q) begin
                        state_q <= IDLE;
                        if (!we_q) begin
                            sbdata_o       <= rd_val;
                            sbdata_valid_o <= 1'b1;
                        end
                        if (sbautoincrement_i) begin
                            addr_q <= addr_q + (BusWidth'(1) << sz_q);
                        end
                    end else if (timeout) begin
                        state_q         <= IDLE;
                        discard_q       <= 1'b1;
                        sberror_o       <= 3'd1;
                        sberror_valid_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_sba_engine.sv
// Self-checking bench for dm_sba_engine (BusWidth=32, TimeoutCycles=8).
module tb_dm_sba_engine;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        dmactive_i = 1'b1;
    logic        master_req_o;
    logic [31:0] master_add_o;
    logic        master_we_o;
    logic [31:0] master_wdata_o;
    logic [3:0]  master_be_o;
    logic        master_gnt_i = 1'b0;
    logic        master_r_valid_i = 1'b0;
    logic [31:0] master_r_rdata_i = '0;
    logic [31:0] sbaddress_i = '0;
    logic [31:0] sbaddress_o;
    logic        sbaddress_write_valid_i = 1'b0;
    logic        sbreadonaddr_i = 1'b0;
    logic        sbautoincrement_i = 1'b0;
    logic [2:0]  sbaccess_i = '0;
    logic        sbreadondata_i = 1'b0;
    logic [31:0] sbdata_i = '0;
    logic        sbdata_read_valid_i = 1'b0;
    logic        sbdata_write_valid_i = 1'b0;
    logic [31:0] sbdata_o;
    logic        sbdata_valid_o;
    logic        sbbusy_o;
    logic        sberror_valid_o;
    logic [2:0]  sberror_o;

    int n_checks = 0;
    int n_fail   = 0;

    dm_sba_engine #(.BusWidth(32), .TimeoutCycles(8), .SupportedSizes(4'b0111)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .dmactive_i(dmactive_i),
        .master_req_o(master_req_o), .master_add_o(master_add_o), .master_we_o(master_we_o),
        .master_wdata_o(master_wdata_o), .master_be_o(master_be_o), .master_gnt_i(master_gnt_i),
        .master_r_valid_i(master_r_valid_i), .master_r_rdata_i(master_r_rdata_i),
        .sbaddress_i(sbaddress_i), .sbaddress_o(sbaddress_o),
        .sbaddress_write_valid_i(sbaddress_write_valid_i), .sbreadonaddr_i(sbreadonaddr_i),
        .sbautoincrement_i(sbautoincrement_i), .sbaccess_i(sbaccess_i),
        .sbreadondata_i(sbreadondata_i), .sbdata_i(sbdata_i),
        .sbdata_read_valid_i(sbdata_read_valid_i), .sbdata_write_valid_i(sbdata_write_valid_i),
        .sbdata_o(sbdata_o), .sbdata_valid_o(sbdata_valid_o), .sbbusy_o(sbbusy_o),
        .sberror_valid_o(sberror_valid_o), .sberror_o(sberror_o)
    );

    always #5 clk_i = ~clk_i;

    typedef enum logic [1:0] {OP_RA, OP_RD, OP_WR, OP_BOTH} op_e;

    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic        autoinc;
        logic [31:0] rdata;
        int          gnt_lat;
        int          rsp_lat;
        logic [2:0]  e_err;
        logic [31:0] e_add;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
        logic [31:0] e_next;
        int          e_busy;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // reference: outcome of one access computed from the access rules
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int unsigned nb;
        int unsigned off;
        logic [63:0] mask;
        r.e_err = 3'd0; r.e_add = '0; r.e_we = 1'b0; r.e_be = '0; r.e_wdata = '0;
        r.e_data = '0; r.e_next = v.addr; r.e_busy = 0;
        if (v.size > 3'd2) begin
            r.e_err = 3'd4;
            return r;
        end
        nb = 32'd1 << v.size;
        if ((v.addr % nb) != 0) begin
            r.e_err = 3'd3;
            return r;
        end
        off     = v.addr % 4;
        r.e_add = v.addr - off;
        r.e_we  = (v.op == OP_WR) || (v.op == OP_BOTH);
        r.e_be  = 4'(((32'd1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++) r.e_wdata[8*i +: 8] = v.data[8*(i % nb) +: 8];
        mask = (64'd1 << (8 * nb)) - 64'd1;
        if (!r.e_we) r.e_data = 32'((64'(v.rdata) >> (8 * off)) & mask);
        if (v.autoinc) r.e_next = v.addr + 32'(nb);
        r.e_busy = v.gnt_lat + v.rsp_lat + 2;
        return r;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [2:0] sz, input logic ai);
        @(negedge clk_i);
        check("pulse_one_cycle", {sbdata_valid_o, sberror_valid_o}, 2'b00);
        sbaddress_i = a; sbaddress_write_valid_i = 1'b1; sbreadonaddr_i = 1'b0;
        sbaccess_i = sz; sbautoincrement_i = ai;
        @(negedge clk_i);
        sbaddress_write_valid_i = 1'b0;
    endtask

    task automatic trigger(input op_e op, input logic [31:0] d);
        sbdata_i = d;
        case (op)
            OP_RA:   begin sbaddress_write_valid_i = 1'b1; sbreadonaddr_i = 1'b1; end
            OP_RD:   begin sbdata_read_valid_i = 1'b1; sbreadondata_i = 1'b1; end
            OP_WR:   sbdata_write_valid_i = 1'b1;
            default: begin sbdata_read_valid_i = 1'b1; sbreadondata_i = 1'b1; sbdata_write_valid_i = 1'b1; end
        endcase
        @(negedge clk_i);
        sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b0;
        sbdata_read_valid_i = 1'b0; sbreadondata_i = 1'b0; sbdata_write_valid_i = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int busy_c = 0, req_c = 0, wcnt = 0;
        bit gnt_done = 0, got_d = 0, got_e = 0, both = 0, done = 0, unstable = 0;
        logic [31:0] c_add = '0, c_wd = '0, d_val = '0;
        logic c_we = 1'b0;
        logic [3:0] c_be = '0;
        logic [2:0] e_val = '0;
        master_r_rdata_i = v.rdata;
        preload(v.addr, v.size, v.autoinc);
        trigger(v.op, v.data);
        for (int k = 0; k < 40 && !done; k++) begin
            if (k > 0) @(negedge clk_i);
            master_gnt_i = 1'b0; master_r_valid_i = 1'b0;
            if (sbdata_valid_o) begin got_d = 1; d_val = sbdata_o; end
            if (sberror_valid_o) begin got_e = 1; e_val = sberror_o; end
            if (sbdata_valid_o && sberror_valid_o) both = 1;
            if (master_req_o) begin
                req_c++;
                if (req_c == 1) begin
                    c_add = master_add_o; c_we = master_we_o; c_be = master_be_o; c_wd = master_wdata_o;
                end else if ({master_add_o, master_we_o, master_be_o, master_wdata_o} != {c_add, c_we, c_be, c_wd}) begin
                    unstable = 1;
                end
            end
            if (!sbbusy_o) done = 1;
            else begin
                busy_c++;
                if (gnt_done) begin
                    if (wcnt == v.rsp_lat) master_r_valid_i = 1'b1;
                    wcnt++;
                end else if (master_req_o && req_c > v.gnt_lat) begin
                    master_gnt_i = 1'b1;
                    gnt_done = 1;
                end
            end
        end
        master_gnt_i = 1'b0; master_r_valid_i = 1'b0;
        check({tag, "/finished"}, done, 1'b1);
        check({tag, "/err_pulse"}, got_e, v.e_err != 3'd0);
        if (v.e_err != 3'd0) check({tag, "/err_code"}, e_val, v.e_err);
        check({tag, "/req_cycles"}, req_c, (v.e_err == 3'd0) ? v.gnt_lat + 1 : 0);
        if (v.e_err == 3'd0) begin
            check({tag, "/add"}, c_add, v.e_add);
            check({tag, "/we"}, c_we, v.e_we);
            check({tag, "/be"}, c_be, v.e_be);
            check({tag, "/req_stable"}, unstable, 1'b0);
            if (v.e_we) check({tag, "/wdata"}, c_wd, v.e_wdata);
            check({tag, "/data_pulse"}, got_d, !v.e_we);
            if (!v.e_we) check({tag, "/rdata"}, d_val, v.e_data);
        end
        check({tag, "/sbaddress"}, sbaddress_o, v.e_next);
        check({tag, "/busy_cycles"}, busy_c, v.e_busy);
        check({tag, "/no_double_pulse"}, both, 1'b0);
    endtask

    vec_t tbl[11];
    vec_t v;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: summary not reached in time");
        $fatal(1);
    end

    initial begin
        int req_c;
        int err_k;
        int dv_c;
        int pick;

        tbl[0]  = '{OP_RA,   32'h0000_1000, 3'd2, 32'h0,        1'b0, 32'h1234_5678, 0, 1, 3'd0, 32'h1000,      1'b0, 4'hF, 32'h0,        32'h1234_5678, 32'h1000, 3};
        tbl[1]  = '{OP_WR,   32'h0000_1003, 3'd0, 32'hAB,       1'b1, 32'h0,         1, 0, 3'd0, 32'h1000,      1'b1, 4'h8, 32'hABAB_ABAB, 32'h0,         32'h1004, 3};
        tbl[2]  = '{OP_RD,   32'h0000_1002, 3'd2, 32'h0,        1'b1, 32'h0,         0, 0, 3'd3, 32'h0,         1'b0, 4'h0, 32'h0,        32'h0,         32'h1002, 0};
        tbl[3]  = '{OP_RD,   32'h0000_1000, 3'd3, 32'h0,        1'b0, 32'h0,         0, 0, 3'd4, 32'h0,         1'b0, 4'h0, 32'h0,        32'h0,         32'h1000, 0};
        tbl[4]  = '{OP_WR,   32'h0000_1002, 3'd3, 32'h0,        1'b0, 32'h0,         0, 0, 3'd4, 32'h0,         1'b0, 4'h0, 32'h0,        32'h0,         32'h1002, 0};
        tbl[5]  = '{OP_RA,   32'hFFFF_FFFC, 3'd2, 32'h0,        1'b1, 32'hCAFE_F00D, 2, 0, 3'd0, 32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0,        32'hCAFE_F00D, 32'h0,    4};
        tbl[6]  = '{OP_BOTH, 32'h0000_2000, 3'd2, 32'h55AA_33CC, 1'b0, 32'h0,        0, 2, 3'd0, 32'h2000,      1'b1, 4'hF, 32'h55AA_33CC, 32'h0,        32'h2000, 4};
        tbl[7]  = '{OP_RD,   32'h0000_1002, 3'd1, 32'h0,        1'b1, 32'hBEEF_1234, 1, 1, 3'd0, 32'h1000,      1'b0, 4'hC, 32'h0,        32'h0000_BEEF, 32'h1004, 4};
        tbl[8]  = '{OP_RD,   32'h0000_1001, 3'd0, 32'h0,        1'b0, 32'h1122_3344, 0, 0, 3'd0, 32'h1000,      1'b0, 4'h2, 32'h0,        32'h0000_0033, 32'h1001, 2};
        tbl[9]  = '{OP_WR,   32'h0000_1000, 3'd1, 32'h1234,     1'b0, 32'h0,         3, 3, 3'd0, 32'h1000,      1'b1, 4'h3, 32'h1234_1234, 32'h0,        32'h1000, 8};
        tbl[10] = '{OP_RD,   32'h0000_1000, 3'd4, 32'h0,        1'b0, 32'h0,         0, 0, 3'd4, 32'h0,         1'b0, 4'h0, 32'h0,        32'h0,         32'h1000, 0};

        // reset state
        repeat (3) @(negedge clk_i);
        check("rst/busy", sbbusy_o, 1'b0);
        check("rst/req", master_req_o, 1'b0);
        check("rst/master_bus", {master_add_o, master_we_o, master_wdata_o, master_be_o}, '0);
        check("rst/sbaddress", sbaddress_o, 32'h0);
        check("rst/sbdata", sbdata_o, 32'h0);
        check("rst/pulses", {sbdata_valid_o, sberror_valid_o}, 2'b00);
        check("rst/sberror", sberror_o, 3'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < 11; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // grant never arrives: error 8 cycles after the request rises
        preload(32'h3000, 3'd2, 1'b0);
        trigger(OP_RD, 32'h0);
        req_c = 0; err_k = -1;
        for (int k = 0; k < 30 && err_k < 0; k++) begin
            if (k > 0) @(negedge clk_i);
            if (master_req_o) req_c++;
            if (sberror_valid_o) err_k = k;
        end
        check("gnt_to/err_cycle", err_k, 8);
        check("gnt_to/req_cycles", req_c, 8);
        check("gnt_to/code", sberror_o, 3'd1);
        check("gnt_to/req_low", {master_req_o, sbbusy_o}, 2'b00);
        master_r_rdata_i = 32'hDEAD_BEEF; master_r_valid_i = 1'b1;
        @(negedge clk_i);
        master_r_valid_i = 1'b0;
        dv_c = 0;
        for (int k = 0; k < 3; k++) begin
            if (sbdata_valid_o) dv_c++;
            @(negedge clk_i);
        end
        check("gnt_to/late_rsp_ignored", dv_c, 0);

        // response never arrives: error 8 cycles after the grant, late response swallowed
        preload(32'h3100, 3'd2, 1'b0);
        trigger(OP_RD, 32'h0);
        check("rsp_to/req", master_req_o, 1'b1);
        master_gnt_i = 1'b1;
        err_k = -1;
        for (int k = 1; k < 30 && err_k < 0; k++) begin
            @(negedge clk_i);
            master_gnt_i = 1'b0;
            if (sberror_valid_o) err_k = k;
        end
        check("rsp_to/err_cycle", err_k, 1 + 8);
        check("rsp_to/code", sberror_o, 3'd1);
        master_r_rdata_i = 32'hFFFF_0000; master_r_valid_i = 1'b1;
        @(negedge clk_i);
        master_r_valid_i = 1'b0;
        check("rsp_to/late_rsp_ignored", sbdata_valid_o, 1'b0);
        v = '{OP_RD, 32'h3200, 3'd2, 32'h0, 1'b0, 32'h0F0F_A5A5, 1, 0, 3'd0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 0};
        apply_vec(model(v), "after_discard");

        // soft clear while waiting for the response
        v = '{OP_RD, 32'h4000, 3'd2, 32'h0, 1'b0, 32'h0BAD_F00D, 0, 0, 3'd0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 0};
        apply_vec(model(v), "pre_dm");
        preload(32'h4000, 3'd2, 1'b0);
        trigger(OP_RD, 32'h0);
        master_gnt_i = 1'b1;
        @(negedge clk_i);
        master_gnt_i = 1'b0;
        check("dm/waiting", {sbbusy_o, master_req_o}, 2'b10);
        dmactive_i = 1'b0;
        @(negedge clk_i);
        check("dm/idle", {sbbusy_o, master_req_o}, 2'b00);
        check("dm/no_pulses", {sbdata_valid_o, sberror_valid_o}, 2'b00);
        check("dm/sberror_cleared", sberror_o, 3'd0);
        check("dm/address_kept", sbaddress_o, 32'h4000);
        check("dm/sbdata_kept", sbdata_o, 32'h0BAD_F00D);
        dmactive_i = 1'b1;
        master_r_valid_i = 1'b1;
        @(negedge clk_i);
        master_r_valid_i = 1'b0;
        check("dm/stale_rsp_ignored", {sbdata_valid_o, sbbusy_o}, 2'b00);

        // randomized accesses against the reference
        for (int i = 0; i < 40; i++) begin
            v.op = op_e'($urandom_range(0, 3));
            pick = $urandom_range(0, 9);
            v.size = (pick < 3) ? 3'd0 : (pick < 5) ? 3'd1 : (pick < 8) ? 3'd2 : (pick == 8) ? 3'd3 : 3'd4;
            v.addr = $urandom;
            if ($urandom_range(0, 3) != 0 && v.size < 3'd3) v.addr = v.addr & ~((32'd1 << v.size) - 32'd1);
            if ($urandom_range(0, 9) == 0) v.addr = 32'hFFFF_FFFC;
            v.data    = $urandom;
            v.rdata   = $urandom;
            v.autoinc = 1'($urandom_range(0, 1));
            v.gnt_lat = $urandom_range(0, 3);
            v.rsp_lat = $urandom_range(0, 3);
            apply_vec(model(v), $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
